// File: rtl/hazard_pkg.sv
// Shared types and defaults for the hazard scoreboard and its countdown entries.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: register-file size default, result-latency defaults, countdown and
// performance-counter widths, the stage in which an instruction consumes its
// sources, and a helper that turns that stage into a countdown threshold.
package hazard_pkg;

  localparam int NREG_DEF     = 32;
  localparam int LOAD_LAT_DEF = 2;
  localparam int ALU_LAT_DEF  = 1;
  localparam int CNT_W        = 3;   // countdown width, holds latencies up to 7
  localparam int PERF_W       = 32;  // performance counter width

  // Where the ID instruction actually reads its sources.
  typedef enum logic {
    USE_EX = 1'b0,
    USE_ID = 1'b1
  } use_stage_e;

  // Largest countdown that is still safe for a consumer in the given stage.
  // A consumer in EX reads one cycle later than one in ID, so it can tolerate
  // a producer that is still one cycle away from forwarding.
  function automatic logic [CNT_W-1:0] need_of(input use_stage_e st);
    return (st == USE_ID) ? CNT_W'(0) : CNT_W'(1);
  endfunction

endpackage

// File: rtl/sb_counter.sv
// Single scoreboard countdown entry: cycles until a register result is forwardable.
// Latency: load/decrement visible the cycle after the qualifying edge.
// Backpressure: freeze holds the value; load beats decrement; reset clears.
//
// Ports:
//   clk, reset     rising-edge clock, asynchronous active-high clear
//   freeze         pipeline frozen, hold the current count
//   load, load_val start a new countdown (newest writer wins)
//   cnt            current countdown, 0 means the result is available
module sb_counter
  import hazard_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         freeze,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (freeze) begin
      cnt <= cnt;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register result-latency scoreboard producing stall/flush/keep controls for a 5-stage pipe.
// Latency: hazard decision is combinational from ID inputs and current countdowns (zero cycles).
// Backpressure: i_mem_busy freezes everything (all keeps 1, no flush, no issue, countdowns hold).
//
// Ports:
//   clk, reset                          rising-edge clock, asynchronous active-high reset
//   i_id_valid                          ID holds a real instruction
//   i_id_rs/i_id_rt, *_use              source registers and whether each is read
//   i_id_use_in_id                      sources consumed in ID (branch compare, jr/jalr)
//   i_id_reg_write, i_id_is_load, i_id_rd  destination description of the ID instruction
//   i_branch_taken, i_jump              redirect resolved in ID this cycle
//   i_mem_busy                          data memory not ready, whole pipe freezes
//   o_pc_keep, o_IF_ID_keep, o_ID_EX_keep  hold controls
//   o_IF_ID_flush, o_ID_EX_flush        bubble insertion
//   o_stall_cycles, o_flush_count       performance counters
//
// Build option: define HAZARD_PERF_CNT_EN to implement the performance counters;
// otherwise both counter ports read 0 and no counter flops exist.
// Legal parameter range: 1 <= ALU_LAT <= LOAD_LAT <= 7.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG     = NREG_DEF,
  parameter int LOAD_LAT = LOAD_LAT_DEF,
  parameter int ALU_LAT  = ALU_LAT_DEF,
  localparam int REG_W   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_id_valid,
  input  logic [REG_W-1:0]  i_id_rs,
  input  logic [REG_W-1:0]  i_id_rt,
  input  logic              i_id_rs_use,
  input  logic              i_id_rt_use,
  input  logic              i_id_use_in_id,
  input  logic              i_id_reg_write,
  input  logic              i_id_is_load,
  input  logic [REG_W-1:0]  i_id_rd,
  input  logic              i_branch_taken,
  input  logic              i_jump,
  input  logic              i_mem_busy,
  output logic              o_pc_keep,
  output logic              o_IF_ID_keep,
  output logic              o_ID_EX_keep,
  output logic              o_IF_ID_flush,
  output logic              o_ID_EX_flush,
  output logic [PERF_W-1:0] o_stall_cycles,
  output logic [PERF_W-1:0] o_flush_count
);

  logic [CNT_W-1:0] cnt [NREG];
  logic [CNT_W-1:0] need;
  logic [CNT_W-1:0] load_val;
  use_stage_e       stage;
  logic             rs_hz;
  logic             rt_hz;
  logic             hz;
  logic             issue;

  assign stage    = i_id_use_in_id ? USE_ID : USE_EX;
  assign need     = need_of(stage);
  assign load_val = i_id_is_load ? CNT_W'(LOAD_LAT) : CNT_W'(ALU_LAT);

  // $0 is hardwired, so it can never be a pending producer.
  assign rs_hz = i_id_rs_use && (i_id_rs != '0) && (cnt[i_id_rs] > need);
  assign rt_hz = i_id_rt_use && (i_id_rt != '0) && (cnt[i_id_rt] > need);
  assign hz    = i_id_valid && (rs_hz || rt_hz);

  assign issue = i_id_valid && !hz && !i_mem_busy && i_id_reg_write && (i_id_rd != '0);

  // One countdown per architectural register; entry 0 is a constant zero.
  for (genvar r = 0; r < NREG; r++) begin : g_entry
    if (r == 0) begin : g_zero
      assign cnt[r] = '0;
    end else begin : g_cnt
      sb_counter #(
        .W (CNT_W)
      ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .freeze   (i_mem_busy),
        .load     (issue && (i_id_rd == REG_W'(r))),
        .load_val (load_val),
        .cnt      (cnt[r])
      );
    end
  end

  // Priority: reset forces quiet outputs, then the memory freeze, then a
  // data hazard (bubble into EX, hold fetch/decode), then redirects.
  always_comb begin
    o_pc_keep     = 1'b0;
    o_IF_ID_keep  = 1'b0;
    o_ID_EX_keep  = 1'b0;
    o_IF_ID_flush = 1'b0;
    o_ID_EX_flush = 1'b0;
    if (reset) begin
      o_pc_keep = 1'b0;
    end else if (i_mem_busy) begin
      o_pc_keep    = 1'b1;
      o_IF_ID_keep = 1'b1;
      o_ID_EX_keep = 1'b1;
    end else if (hz) begin
      o_pc_keep     = 1'b1;
      o_IF_ID_keep  = 1'b1;
      o_ID_EX_flush = 1'b1;
    end else begin
      // A taken branch also kills its delay-slot-less successor in ID_EX;
      // a jump only needs the wrong-path fetch in IF_ID removed.
      o_IF_ID_flush = i_branch_taken | i_jump;
      o_ID_EX_flush = i_branch_taken;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] stall_q;
  logic [PERF_W-1:0] flush_q;

  // Stall cycles count only hazard bubbles, not memory freezes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_q + PERF_W'(hz && !i_mem_busy);
      flush_q <= flush_q + PERF_W'(o_IF_ID_flush);
    end
  end

  assign o_stall_cycles = stall_q;
  assign o_flush_count  = flush_q;
`else
  assign o_stall_cycles = '0;
  assign o_flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: per-cycle expected control vectors
// are queued when stimulus is driven and compared on the following falling edge.
// Control vector order: {pc_keep, IF_ID_keep, ID_EX_keep, IF_ID_flush, ID_EX_flush}.
module tb_hazard_scoreboard;

  localparam logic [4:0] E_GO    = 5'b00000;
  localparam logic [4:0] E_STALL = 5'b11001;
  localparam logic [4:0] E_BUSY  = 5'b11100;
  localparam logic [4:0] E_JMP   = 5'b00010;
  localparam logic [4:0] E_BR    = 5'b00011;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [31:0] EXP_STALLS  = 32'd3;
  localparam logic [31:0] EXP_FLUSHES = 32'd2;
`else
  localparam logic [31:0] EXP_STALLS  = 32'd0;
  localparam logic [31:0] EXP_FLUSHES = 32'd0;
`endif

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rsu;
    logic       rtu;
    logic       uid;
    logic       rw;
    logic       ld;
    logic [4:0] rd;
    logic       br;
    logic       jmp;
    logic       busy;
  } stim_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_id_valid;
  logic [4:0]  i_id_rs, i_id_rt, i_id_rd;
  logic        i_id_rs_use, i_id_rt_use, i_id_use_in_id;
  logic        i_id_reg_write, i_id_is_load;
  logic        i_branch_taken, i_jump, i_mem_busy;
  logic        o_pc_keep, o_IF_ID_keep, o_ID_EX_keep, o_IF_ID_flush, o_ID_EX_flush;
  logic [31:0] o_stall_cycles, o_flush_count;
  logic [4:0]  outs;

  int n_vec = 0;
  int n_err = 0;

  string      tag_q[$];
  logic [4:0] exp_q[$];

  assign outs = {o_pc_keep, o_IF_ID_keep, o_ID_EX_keep, o_IF_ID_flush, o_ID_EX_flush};

  hazard_scoreboard dut (
    .clk            (clk),
    .reset          (reset),
    .i_id_valid     (i_id_valid),
    .i_id_rs        (i_id_rs),
    .i_id_rt        (i_id_rt),
    .i_id_rs_use    (i_id_rs_use),
    .i_id_rt_use    (i_id_rt_use),
    .i_id_use_in_id (i_id_use_in_id),
    .i_id_reg_write (i_id_reg_write),
    .i_id_is_load   (i_id_is_load),
    .i_id_rd        (i_id_rd),
    .i_branch_taken (i_branch_taken),
    .i_jump         (i_jump),
    .i_mem_busy     (i_mem_busy),
    .o_pc_keep      (o_pc_keep),
    .o_IF_ID_keep   (o_IF_ID_keep),
    .o_ID_EX_keep   (o_ID_EX_keep),
    .o_IF_ID_flush  (o_IF_ID_flush),
    .o_ID_EX_flush  (o_ID_EX_flush),
    .o_stall_cycles (o_stall_cycles),
    .o_flush_count  (o_flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  function automatic stim_t f_nop();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t f_alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    stim_t s;
    s = '0;
    s.v = 1'b1; s.rs = rs; s.rt = rt; s.rsu = 1'b1; s.rtu = 1'b1;
    s.rw = 1'b1; s.rd = rd;
    return s;
  endfunction

  function automatic stim_t f_ld(input logic [4:0] rd, input logic [4:0] rs);
    stim_t s;
    s = '0;
    s.v = 1'b1; s.rs = rs; s.rsu = 1'b1; s.rw = 1'b1; s.ld = 1'b1; s.rd = rd;
    return s;
  endfunction

  function automatic stim_t f_beq(input logic [4:0] rs, input logic [4:0] rt, input logic taken);
    stim_t s;
    s = '0;
    s.v = 1'b1; s.rs = rs; s.rt = rt; s.rsu = 1'b1; s.rtu = 1'b1;
    s.uid = 1'b1; s.br = taken;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    i_id_valid     = s.v;
    i_id_rs        = s.rs;
    i_id_rt        = s.rt;
    i_id_rs_use    = s.rsu;
    i_id_rt_use    = s.rtu;
    i_id_use_in_id = s.uid;
    i_id_reg_write = s.rw;
    i_id_is_load   = s.ld;
    i_id_rd        = s.rd;
    i_branch_taken = s.br;
    i_jump         = s.jmp;
    i_mem_busy     = s.busy;
  endtask

  // Drive one ID cycle and queue the controls it must produce.
  task automatic cyc(input string tag, input stim_t s, input logic [4:0] e);
    @(posedge clk);
    #1;
    apply(s);
    tag_q.push_back(tag);
    exp_q.push_back(e);
  endtask

  // Asynchronous reset pulse between edges; outputs must drop at once.
  task automatic rst_pulse(input string tag);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk({tag, "_outs"}, 32'(outs), 32'd0);
    chk({tag, "_stall"}, o_stall_cycles, 32'd0);
    chk({tag, "_flush"}, o_flush_count, 32'd0);
    #1;
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (tag_q.size() != 0) begin
      chk(tag_q.pop_front(), 32'(outs), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    stim_t s;
    reset = 1'b1;
    apply(f_nop());
    #3;
    chk("rst_outs", 32'(outs), 32'd0);
    chk("rst_stall", o_stall_cycles, 32'd0);
    chk("rst_flush", o_flush_count, 32'd0);
    // Hazard-looking ID inputs must still give quiet outputs under reset.
    apply(f_alu(3, 1, 2));
    i_mem_busy = 1'b1;
    #1;
    chk("rst_busy_outs", 32'(outs), 32'd0);
    apply(f_nop());
    @(negedge clk);
    reset = 1'b0;

    cyc("idle", f_nop(), E_GO);

    // Load-use: one bubble, then proceed.
    cyc("lu_lw",   f_ld(8, 1),       E_GO);
    cyc("lu_st",   f_alu(10, 8, 2),  E_STALL);
    cyc("lu_go",   f_alu(10, 8, 2),  E_GO);
    // Same through rt.
    cyc("lu_rt_lw", f_ld(4, 1),      E_GO);
    cyc("lu_rt_st", f_alu(16, 2, 4), E_STALL);
    cyc("lu_rt_go", f_alu(16, 2, 4), E_GO);

    // ALU to branch: one bubble, redirect suppressed while stalled.
    cyc("ab_add",  f_alu(9, 1, 2),   E_GO);
    cyc("ab_st",   f_beq(9, 3, 1),   E_STALL);
    cyc("ab_br",   f_beq(9, 3, 1),   E_BR);
    // Load to branch: two bubbles.
    cyc("lb_lw",   f_ld(9, 1),       E_GO);
    cyc("lb_st1",  f_beq(9, 3, 0),   E_STALL);
    cyc("lb_st2",  f_beq(9, 3, 0),   E_STALL);
    cyc("lb_go",   f_beq(9, 3, 0),   E_GO);
    s = f_nop(); s.v = 1'b1; s.jmp = 1'b1;
    cyc("jmp",     s,                E_JMP);

    // Memory freeze holds the countdown; load-use bubble follows the release.
    cyc("mb_lw",   f_ld(8, 1),       E_GO);
    s = f_alu(11, 8, 2); s.busy = 1'b1; s.br = 1'b1;
    cyc("mb_b1",   s,                E_BUSY);
    cyc("mb_b2",   s,                E_BUSY);
    cyc("mb_b3",   s,                E_BUSY);
    cyc("mb_st",   f_alu(11, 8, 2),  E_STALL);
    cyc("mb_go",   f_alu(11, 8, 2),  E_GO);

    // Register $0 never hazards.
    cyc("z_wr",    f_alu(0, 1, 2),   E_GO);
    cyc("z_use",   f_alu(12, 0, 0),  E_GO);
    cyc("z_lw",    f_ld(0, 1),       E_GO);
    cyc("z_beq",   f_beq(0, 0, 0),   E_GO);
    // Unused source does not hazard.
    cyc("nu_lw",   f_ld(7, 1),       E_GO);
    s = f_alu(15, 7, 2); s.rsu = 1'b0;
    cyc("nu_add",  s,                E_GO);
    // Newest writer wins, both directions.
    cyc("ow_lw",   f_ld(5, 1),       E_GO);
    cyc("ow_add",  f_alu(5, 1, 2),   E_GO);
    cyc("ow_use",  f_alu(13, 5, 2),  E_GO);
    cyc("ow2_add", f_alu(6, 1, 2),   E_GO);
    cyc("ow2_lw",  f_ld(6, 1),       E_GO);
    cyc("ow2_st",  f_alu(14, 6, 2),  E_STALL);
    cyc("ow2_go",  f_alu(14, 6, 2),  E_GO);

    // Reset in the middle of a load-to-branch stall empties the scoreboard.
    cyc("rs_lw",   f_ld(9, 1),       E_GO);
    cyc("rs_st",   f_beq(9, 3, 0),   E_STALL);
    rst_pulse("rs_mid");
    cyc("rs_go",   f_beq(9, 3, 0),   E_GO);

    // Performance counters: three load-use pairs, two taken branches.
    cyc("pf_lw1",  f_ld(8, 1),       E_GO);
    cyc("pf_st1",  f_alu(10, 8, 2),  E_STALL);
    cyc("pf_go1",  f_alu(10, 8, 2),  E_GO);
    cyc("pf_lw2",  f_ld(9, 1),       E_GO);
    s = f_alu(10, 9, 2); s.busy = 1'b1;
    cyc("pf_bz2",  s,                E_BUSY);
    cyc("pf_st2",  f_alu(10, 9, 2),  E_STALL);
    cyc("pf_go2",  f_alu(10, 9, 2),  E_GO);
    cyc("pf_lw3",  f_ld(4, 1),       E_GO);
    cyc("pf_st3",  f_alu(16, 2, 4),  E_STALL);
    cyc("pf_go3",  f_alu(16, 2, 4),  E_GO);
    cyc("pf_br1",  f_beq(1, 2, 1),   E_BR);
    cyc("pf_br2",  f_beq(3, 2, 1),   E_BR);
    cyc("pf_idle", f_nop(),          E_GO);
    @(negedge clk);
    #1;
    chk("perf_stall", o_stall_cycles, EXP_STALLS);
    chk("perf_flush", o_flush_count, EXP_FLUSHES);

    repeat (2) @(negedge clk);
    chk("drain", 32'(tag_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
